// File: rtl/id_stage_pkg.sv
// Shared definitions for the MIPS instruction-decode stage: opcodes, control
// field layout and the opcode-to-control decode function.
package id_stage_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int RIDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  // EX = {regdst, aluop[1:0], alusrc}; M = {branch, memread, memwrite}; WB = {regwrite, memtoreg}
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    unique case (opcode)
      OP_RTYPE: begin c.ex = 4'b1100; c.m = 3'b000; c.wb = 2'b10; end
      OP_LW:    begin c.ex = 4'b0001; c.m = 3'b010; c.wb = 2'b11; end
      OP_SW:    begin c.ex = 4'b0001; c.m = 3'b001; c.wb = 2'b00; end
      OP_BEQ:   begin c.ex = 4'b0010; c.m = 3'b100; c.wb = 2'b00; end
      default:  c = '0;  // unsupported opcode becomes a side-effect-free bubble
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, $0 hardwired to zero, synchronous reset clearing all entries.
module id_regfile
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RIDX_W-1:0] ra1_i,
  input  logic [RIDX_W-1:0] ra2_i,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i,
  output logic [XLEN-1:0]   rd1_o,
  output logic [XLEN-1:0]   rd2_o
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // A write landing this cycle is forwarded so ID sees the value WB is committing.
  always_comb begin
    rd1_o = mem_q[ra1_i];
    if (ra1_i == '0) begin
      rd1_o = '0;
    end else if (wr_en && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end
  end

  always_comb begin
    rd2_o = mem_q[ra2_i];
    if (ra2_i == '0) begin
      rd2_o = '0;
    end else if (wr_en && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: control decode, register read, sign extension
// and the ID/EX pipeline register feeding EX.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_id_instr,
  input  logic [XLEN-1:0]   if_id_npc,
  input  logic [RIDX_W-1:0] mem_wb_rd,
  input  logic              mem_wb_regwrite,
  input  logic [XLEN-1:0]   wb_writedata,
  output logic [WB_W-1:0]   wb_ctlout,
  output logic [M_W-1:0]    m_ctlout,
  output logic              regdst,
  output logic              alusrc,
  output logic [1:0]        aluop,
  output logic [XLEN-1:0]   npcout,
  output logic [XLEN-1:0]   rdata1out,
  output logic [XLEN-1:0]   rdata2out,
  output logic [XLEN-1:0]   s_extendout,
  output logic [RIDX_W-1:0] instrout_2016,
  output logic [RIDX_W-1:0] instrout_1511
);

  ctrl_t             ctrl_d,  ctrl_q;
  logic [XLEN-1:0]   npc_d,   npc_q;
  logic [XLEN-1:0]   rdata1_d, rdata1_q;
  logic [XLEN-1:0]   rdata2_d, rdata2_q;
  logic [XLEN-1:0]   sext_d,  sext_q;
  logic [RIDX_W-1:0] rt_d,    rt_q;
  logic [RIDX_W-1:0] rd_d,    rd_q;

  id_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (if_id_instr[25:21]),
    .ra2_i (if_id_instr[20:16]),
    .we_i  (mem_wb_regwrite),
    .wa_i  (mem_wb_rd),
    .wd_i  (wb_writedata),
    .rd1_o (rdata1_d),
    .rd2_o (rdata2_d)
  );

  always_comb begin
    ctrl_d = decode_ctrl(if_id_instr[31:26]);
    npc_d  = if_id_npc;
    sext_d = sign_ext16(if_id_instr[15:0]);
    rt_d   = if_id_instr[20:16];
    rd_d   = if_id_instr[15:11];
  end

  // ID/EX boundary: reset clears everything so EX sees a clean bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      npc_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      sext_q   <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      npc_q    <= npc_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      sext_q   <= sext_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
    end
  end

  assign wb_ctlout     = ctrl_q.wb;
  assign m_ctlout      = ctrl_q.m;
  assign regdst        = ctrl_q.ex[EX_REGDST];
  assign aluop         = ctrl_q.ex[EX_ALUOP_HI:EX_ALUOP_LO];
  assign alusrc        = ctrl_q.ex[EX_ALUSRC];
  assign npcout        = npc_q;
  assign rdata1out     = rdata1_q;
  assign rdata2out     = rdata2_q;
  assign s_extendout   = sext_q;
  assign instrout_2016 = rt_q;
  assign instrout_1511 = rd_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared against an array-based behavioural model of the decode stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite;
  logic [31:0] wb_writedata;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npcout;
  logic [31:0] rdata1out;
  logic [31:0] rdata2out;
  logic [31:0] s_extendout;
  logic [4:0]  instrout_2016;
  logic [4:0]  instrout_1511;

  int errors = 0;
  int checks = 0;

  logic [31:0]  rf_m [32];
  logic [146:0] exp_v;
  logic [146:0] obs;
  logic [8:0]   ctl_obs;

  always #5 clk = ~clk;

  id_stage dut (
    .clk             (clk),
    .rst             (rst),
    .if_id_instr     (if_id_instr),
    .if_id_npc       (if_id_npc),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .wb_writedata    (wb_writedata),
    .wb_ctlout       (wb_ctlout),
    .m_ctlout        (m_ctlout),
    .regdst          (regdst),
    .alusrc          (alusrc),
    .aluop           (aluop),
    .npcout          (npcout),
    .rdata1out       (rdata1out),
    .rdata2out       (rdata2out),
    .s_extendout     (s_extendout),
    .instrout_2016   (instrout_2016),
    .instrout_1511   (instrout_1511)
  );

  // {wb, m, regdst, aluop, alusrc}
  assign ctl_obs = {wb_ctlout, m_ctlout, regdst, aluop, alusrc};
  assign obs = {ctl_obs, npcout, rdata1out, rdata2out, s_extendout, instrout_2016, instrout_1511};

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (mem_wb_regwrite && mem_wb_rd == idx) return wb_writedata;
    return rf_m[idx];
  endfunction

  function automatic logic [146:0] model_expect();
    logic [8:0]  c;
    logic [31:0] sx;
    if (rst) return '0;
    case (if_id_instr[31:26])
      6'b000000: c = 9'b10_000_1_10_0;
      6'b100011: c = 9'b11_010_0_00_1;
      6'b101011: c = 9'b00_001_0_00_1;
      6'b000100: c = 9'b00_100_0_01_0;
      default:   c = 9'b0;
    endcase
    sx = 32'($signed(if_id_instr[15:0]));
    return {c, if_id_npc, model_read(if_id_instr[25:21]), model_read(if_id_instr[20:16]),
            sx, if_id_instr[20:16], if_id_instr[15:11]};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] npc,
                       input logic we, input logic [4:0] rd, input logic [31:0] wd);
    if_id_instr     = instr;
    if_id_npc       = npc;
    mem_wb_regwrite = we;
    mem_wb_rd       = rd;
    wb_writedata    = wd;
  endtask

  task automatic step();
    exp_v = model_expect();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    end else if (mem_wb_regwrite && mem_wb_rd != 5'd0) begin
      rf_m[mem_wb_rd] = wb_writedata;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h8C22_FFFC, 32'h0000_1004, 1'b1, 5'd7, 32'h5555_AAAA);
    step();
    step();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    rst = 1'b0;
  endtask

  task automatic test_regs_zero();
    for (int i = 1; i < 32; i++) begin
      drive({6'b111111, 5'(i), 5'(i), 16'h0}, 32'd0, 1'b0, 5'd0, 32'd0);
      step();
      checks++;
      if (rdata1out !== 32'd0 || rdata2out !== 32'd0) begin
        errors++;
        $display("FAIL reg_zero[%0d]: got %h/%h want 0", i, rdata1out, rdata2out);
      end
    end
  endtask

  task automatic test_writeback_rtype();
    drive(32'h0, 32'h4, 1'b1, 5'd1, 32'h0000_0005);
    step();
    drive(32'h0, 32'h8, 1'b1, 5'd2, 32'h0000_000A);
    step();
    drive(32'h0022_1820, 32'h0000_0104, 1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (rdata1out !== 32'd5 || rdata2out !== 32'hA) begin
      errors++;
      $display("FAIL add_rdata: got %h/%h want 5/a", rdata1out, rdata2out);
    end
    checks++;
    if (ctl_obs !== 9'b10_000_1_10_0 || instrout_1511 !== 5'd3 || npcout !== 32'h104) begin
      errors++;
      $display("FAIL add_ctl: got ctl=%b rd=%0d npc=%h want 100001100 3 104",
               ctl_obs, instrout_1511, npcout);
    end
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL add_model: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_mem_branch();
    drive(32'h8C22_FFFC, 32'h200, 1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (wb_ctlout !== 2'b11 || m_ctlout !== 3'b010 || alusrc !== 1'b1 ||
        s_extendout !== 32'hFFFF_FFFC || instrout_2016 !== 5'd2) begin
      errors++;
      $display("FAIL lw: got wb=%b m=%b src=%b sx=%h rt=%0d want 11 010 1 fffffffc 2",
               wb_ctlout, m_ctlout, alusrc, s_extendout, instrout_2016);
    end
    drive(32'hAC22_0004, 32'h204, 1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (m_ctlout !== 3'b001 || wb_ctlout !== 2'b00 || s_extendout !== 32'h4) begin
      errors++;
      $display("FAIL sw: got m=%b wb=%b sx=%h want 001 00 4", m_ctlout, wb_ctlout, s_extendout);
    end
    drive(32'h1022_0003, 32'h208, 1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (m_ctlout !== 3'b100 || aluop !== 2'b01 || alusrc !== 1'b0) begin
      errors++;
      $display("FAIL beq: got m=%b aluop=%b src=%b want 100 01 0", m_ctlout, aluop, alusrc);
    end
  endtask

  task automatic test_zero_reg();
    drive(32'h0000_0000, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step();
    checks++;
    if (rdata1out !== 32'd0) begin
      errors++;
      $display("FAIL zero_same_cycle: got %h want 0", rdata1out);
    end
    drive(32'h0000_0000, 32'h0, 1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (rdata1out !== 32'd0 || rdata2out !== 32'd0) begin
      errors++;
      $display("FAIL zero_after: got %h/%h want 0", rdata1out, rdata2out);
    end
  endtask

  task automatic test_bypass();
    drive(32'h0080_0000, 32'h0, 1'b1, 5'd4, 32'h0000_1234);
    step();
    checks++;
    if (rdata1out !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_rs: got %h want 1234", rdata1out);
    end
    drive(32'h0004_0000, 32'h0, 1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (rdata2out !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_stored: got %h want 1234", rdata2out);
    end
  endtask

  task automatic test_unknown_opcode();
    drive(32'hFC22_1820, 32'h300, 1'b0, 5'd0, 32'd0);
    step();
    checks++;
    if (ctl_obs !== 9'd0) begin
      errors++;
      $display("FAIL unknown_ctl: got %b want 0", ctl_obs);
    end
    checks++;
    if (rdata1out !== 32'd5 || npcout !== 32'h300) begin
      errors++;
      $display("FAIL unknown_data: got %h npc=%h want 5 300", rdata1out, npcout);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [5:0]  op;
    logic [4:0]  wrd;
    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        default: op = 6'($urandom());
      endcase
      wrd = ($urandom_range(0, 3) == 0) ? r[25:21] : 5'($urandom());
      drive({op, r[25:0]}, $urandom(), 1'($urandom()), wrd, $urandom());
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_clears();
    drive(32'h0, 32'h0, 1'b1, 5'd9, 32'hCAFE_F00D);
    step();
    rst = 1'b1;
    drive(32'h0022_1820, 32'h44, 1'b1, 5'd5, 32'h7777_7777);
    step();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h want 0", obs);
    end
    rst = 1'b0;
    test_regs_zero();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 5'd0, 32'd0);
    test_reset();
    test_regs_zero();
    test_writeback_rtype();
    test_mem_branch();
    test_zero_reg();
    test_bypass();
    test_unknown_opcode();
    test_random();
    test_reset_clears();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
